// File: rtl/mpmc11_state_seq.sv
// mpmc11 controller state sequencer: one arbiter burst -> MIG-style UI command/write-data handshakes.
// Optional UI-stall watchdog is compiled in with `define MPMC11_SEQ_WATCHDOG_EN.
package mpmc11_pkg;
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESET1     = 3'd1,
    PRESET2     = 3'd2,
    WRITE_DATA0 = 3'd3,
    WRITE_DATA1 = 3'd4,
    READ_DATA0  = 3'd5,
    READ_DATA1  = 3'd6,
    WAIT_NACK   = 3'd7
  } mpmc11_state_t;
endpackage

module mpmc11_state_seq
  import mpmc11_pkg::*;
#(
  parameter int AW     = 32,
  parameter int LW     = 6,
  parameter int STRIDE = 16,
  parameter int TMO    = 1023
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req,
  input  logic          req_we,
  input  logic [AW-1:0] req_adr,
  input  logic [LW-1:0] req_len,
  input  logic          mem_ui_rdy,
  input  logic          mem_wdf_rdy,
  input  logic          mem_rd_valid,
  output mpmc11_state_t state,
  output logic          req_ack,
  output logic          mem_en,
  output logic [2:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wdf_wren,
  output logic          mem_wdf_end,
  output logic          done,
  output logic          err
);

  // Handshakes: a UI transfer happens on a clk edge where the valid output
  // (mem_en / mem_wdf_wren) and the matching ready input are both high.
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  mpmc11_state_t state_q, state_d;
  logic          we_q;
  logic [LW-1:0] len_q;
  logic [AW-1:0] addr_q;
  logic [LW:0]   beat_q;
  logic [LW:0]   ret_q;
  logic          req_ack_q;

  logic last_beat;
  logic rd_state;
  logic ret_done;
  logic wdog_abort;

  assign last_beat = (beat_q == {1'b0, len_q});
  assign rd_state  = (state_q == READ_DATA0) || (state_q == READ_DATA1);
  // A return arriving this cycle counts toward completion immediately.
  assign ret_done  = ((ret_q + (LW+1)'(mem_rd_valid)) == ({1'b0, len_q} + (LW+1)'(1)));

`ifdef MPMC11_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TMO + 1);
  logic [WW-1:0] wdog_q;
  assign wdog_abort = (wdog_q == WW'(TMO));
  assign err        = wdog_abort;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign wdog_abort = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (req) state_d = PRESET1;
      PRESET1:     state_d = PRESET2;
      PRESET2:     state_d = we_q ? WRITE_DATA0 : READ_DATA0;
      WRITE_DATA0: if (mem_wdf_rdy) state_d = WRITE_DATA1;
      WRITE_DATA1: if (mem_ui_rdy) state_d = last_beat ? WAIT_NACK : WRITE_DATA0;
      READ_DATA0:  if (mem_ui_rdy && last_beat) state_d = READ_DATA1;
      READ_DATA1:  if (ret_done) state_d = WAIT_NACK;
      WAIT_NACK:   if (!req) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    if (wdog_abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      len_q     <= '0;
      addr_q    <= '0;
      beat_q    <= '0;
      ret_q     <= '0;
      req_ack_q <= 1'b0;
`ifdef MPMC11_SEQ_WATCHDOG_EN
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_ack_q <= (state_q == IDLE) && req;
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q   <= req_we;
            addr_q <= req_adr;
            len_q  <= req_len;
            beat_q <= '0;
            ret_q  <= '0;
          end
        end
        WRITE_DATA1, READ_DATA0: begin
          if (mem_ui_rdy) begin
            addr_q <= addr_q + AW'(STRIDE);
            if (!last_beat) beat_q <= beat_q + (LW+1)'(1);
          end
        end
        default: ;
      endcase
      if (rd_state && mem_rd_valid) ret_q <= ret_q + (LW+1)'(1);
`ifdef MPMC11_SEQ_WATCHDOG_EN
      // Only time spent waiting inside one active state is counted.
      if ((state_d != state_q) || (state_q == IDLE) || (state_q == WAIT_NACK))
        wdog_q <= '0;
      else
        wdog_q <= wdog_q + WW'(1);
`endif
    end
  end

  assign state        = state_q;
  assign req_ack      = req_ack_q;
  assign mem_en       = (state_q == WRITE_DATA1) || (state_q == READ_DATA0);
  assign mem_cmd      = (state_q == WRITE_DATA1) ? CMD_WR : CMD_RD;
  assign mem_addr     = mem_en ? addr_q : '0;
  assign mem_wdf_wren = (state_q == WRITE_DATA0);
  assign mem_wdf_end  = (state_q == WRITE_DATA0);
  assign done         = (state_q == WAIT_NACK);

endmodule

// File: tb/tb_mpmc11_state_seq.sv
// Bench for mpmc11_state_seq: directed bursts, UI events checked against an expected-event queue.
module tb_mpmc11_state_seq;
  import mpmc11_pkg::*;

  localparam int AW = 32;
  localparam int LW = 6;
  localparam int W  = 40;
  localparam logic [3:0] K_ACK  = 4'd1;
  localparam logic [3:0] K_WDF  = 4'd2;
  localparam logic [3:0] K_CMD  = 4'd3;
  localparam logic [3:0] K_DONE = 4'd4;
  localparam logic [3:0] K_ERR  = 4'd5;

  logic          clk, rstn, req, req_we;
  logic [AW-1:0] req_adr;
  logic [LW-1:0] req_len;
  logic          mem_ui_rdy, mem_wdf_rdy, mem_rd_valid;
  mpmc11_state_t state;
  logic          req_ack, mem_en, mem_wdf_wren, mem_wdf_end, done, err;
  logic [2:0]    mem_cmd;
  logic [AW-1:0] mem_addr;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ret_due[$];
  bit ret_auto = 0;
  bit toggle = 0;
  int ret_cnt = 0;
  int last_ret_cyc = 0;
  logic done_prev = 1'b0;

  mpmc11_state_seq #(.AW(AW), .LW(LW), .STRIDE(16), .TMO(15)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_we(req_we), .req_adr(req_adr),
    .req_len(req_len), .mem_ui_rdy(mem_ui_rdy), .mem_wdf_rdy(mem_wdf_rdy),
    .mem_rd_valid(mem_rd_valid), .state(state), .req_ack(req_ack),
    .mem_en(mem_en), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdf_wren(mem_wdf_wren), .mem_wdf_end(mem_wdf_end), .done(done), .err(err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time %0t exceeded, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] ev(logic [3:0] k, logic [2:0] c, logic [31:0] a);
    return {k, 1'b0, c, a};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: one clock per call; inputs change 1 time unit after posedge.
  task automatic step();
    @(negedge clk);
    if (ret_auto && mem_en && mem_cmd == 3'b001 && mem_ui_rdy) ret_due.push_back(cyc + 5);
    @(posedge clk);
    #1;
    cyc++;
    if (ret_auto) begin
      mem_rd_valid = 1'b0;
      if (ret_due.size() > 0 && ret_due[0] == cyc) begin
        void'(ret_due.pop_front());
        mem_rd_valid = 1'b1;
        ret_cnt++;
        last_ret_cyc = cyc;
      end
    end
    if (toggle) mem_ui_rdy = ~mem_ui_rdy;
  endtask

  task automatic wait_state(mpmc11_state_t s, int budget, string name);
    int n = 0;
    while (state !== s && n < budget) begin
      step();
      n++;
    end
    check(name, state, s);
  endtask

  task automatic issue(logic we, logic [AW-1:0] adr, logic [LW-1:0] len);
    req     = 1'b1;
    req_we  = we;
    req_adr = adr;
    req_len = len;
  endtask

  // Scoreboard monitor
  task automatic sb_check(string name, logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got unexpected event 0x%0h, expected none", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (req_ack) sb_check("ev_req_ack", ev(K_ACK, 3'b0, 32'h0));
      if (mem_wdf_wren && mem_wdf_rdy) sb_check("ev_wdf", ev(K_WDF, 3'b0, {31'b0, mem_wdf_end}));
      if (mem_en && mem_ui_rdy) sb_check("ev_cmd", ev(K_CMD, mem_cmd, mem_addr));
      if (done && !done_prev) sb_check("ev_done", ev(K_DONE, 3'b0, 32'h0));
      if (err) sb_check("ev_err", ev(K_ERR, 3'b0, 32'h0));
    end
    done_prev = done;
  end

  mpmc11_state_t wr_seq[9] = '{PRESET1, PRESET2, WRITE_DATA0, WRITE_DATA1, WRITE_DATA0,
                               WRITE_DATA1, WRITE_DATA0, WRITE_DATA1, WAIT_NACK};

  initial begin
    rstn = 1'b0; req = 1'b0; req_we = 1'b0; req_adr = '0; req_len = '0;
    mem_ui_rdy = 1'b1; mem_wdf_rdy = 1'b1; mem_rd_valid = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step();
    check("rst_state", state, IDLE);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_cmd", mem_cmd, 3'b001);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wren", mem_wdf_wren, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rstn = 1'b1;
    step();
    check("rst_req_ack", req_ack, 0);

    // Write burst, 3 beats, always-ready UI
    exp_q.push_back(ev(K_ACK, 3'b0, 32'h0));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ev(K_WDF, 3'b0, 32'h1));
      exp_q.push_back(ev(K_CMD, 3'b000, 32'h1000 + 32'(16 * i)));
    end
    exp_q.push_back(ev(K_DONE, 3'b0, 32'h0));
    issue(1'b1, 32'h1000, 6'd2);
    for (int i = 0; i < 9; i++) begin
      step();
      check("wr_state", state, wr_seq[i]);
      if (i == 0) check("wr_ack_pulse", req_ack, 1);
      if (i == 1) check("wr_ack_once", req_ack, 0);
    end
    repeat (3) begin
      step();
      check("wr_done_held", done, 1);
    end
    req = 1'b0;
    step();
    check("wr_idle", state, IDLE);
    check("wr_done_clr", done, 0);

    // Read burst, 4 beats, toggling ui_rdy, returns 5 cycles after each command
    exp_q.push_back(ev(K_ACK, 3'b0, 32'h0));
    for (int i = 0; i < 4; i++) exp_q.push_back(ev(K_CMD, 3'b001, 32'h2000 + 32'(16 * i)));
    exp_q.push_back(ev(K_DONE, 3'b0, 32'h0));
    ret_auto = 1; toggle = 1; ret_cnt = 0;
    issue(1'b0, 32'h2000, 6'd3);
    wait_state(WAIT_NACK, 80, "rdt_reach_wait");
    check("rdt_ret_count", ret_cnt, 4);
    check("rdt_exit_after_last_ret", last_ret_cyc, cyc - 1);
    req = 1'b0; toggle = 0; ret_auto = 0; mem_rd_valid = 1'b0; mem_ui_rdy = 1'b1;
    step();
    check("rdt_idle", state, IDLE);

    // Read burst with a return in the same cycle as the first command accept
    exp_q.push_back(ev(K_ACK, 3'b0, 32'h0));
    for (int i = 0; i < 4; i++) exp_q.push_back(ev(K_CMD, 3'b001, 32'h3000 + 32'(16 * i)));
    exp_q.push_back(ev(K_DONE, 3'b0, 32'h0));
    issue(1'b0, 32'h3000, 6'd3);
    repeat (3) step();
    check("rds_enter_rd0", state, READ_DATA0);
    mem_rd_valid = 1'b1;
    step();
    mem_rd_valid = 1'b0;
    repeat (3) step();
    check("rds_in_rd1", state, READ_DATA1);
    mem_rd_valid = 1'b1; step(); mem_rd_valid = 1'b0; step();
    mem_rd_valid = 1'b1; step(); mem_rd_valid = 1'b0; step(); step();
    check("rds_hold_at3", state, READ_DATA1);
    mem_rd_valid = 1'b1; step(); mem_rd_valid = 1'b0;
    check("rds_done_at4", state, WAIT_NACK);
    mem_rd_valid = 1'b1; step(); mem_rd_valid = 1'b0;
    check("rds_stray_ret", state, WAIT_NACK);
    req = 1'b0;
    step();
    check("rds_idle", state, IDLE);

    // Address wrap at the top of the space
    exp_q.push_back(ev(K_ACK, 3'b0, 32'h0));
    exp_q.push_back(ev(K_WDF, 3'b0, 32'h1));
    exp_q.push_back(ev(K_CMD, 3'b000, 32'hFFFF_FFF0));
    exp_q.push_back(ev(K_WDF, 3'b0, 32'h1));
    exp_q.push_back(ev(K_CMD, 3'b000, 32'h0000_0000));
    exp_q.push_back(ev(K_DONE, 3'b0, 32'h0));
    issue(1'b1, 32'hFFFF_FFF0, 6'd1);
    wait_state(WAIT_NACK, 30, "wrap_reach_wait");
    req = 1'b0;
    step();
    check("wrap_idle", state, IDLE);

    // Reset in the middle of a stalled write
    exp_q.push_back(ev(K_ACK, 3'b0, 32'h0));
    exp_q.push_back(ev(K_WDF, 3'b0, 32'h1));
    mem_ui_rdy = 1'b0;
    issue(1'b1, 32'h4000, 6'd3);
    repeat (5) step();
    check("mrst_stalled", state, WRITE_DATA1);
    rstn = 1'b0; req = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    check("mrst_state", state, IDLE);
    check("mrst_mem_en", mem_en, 0);
    check("mrst_wren", mem_wdf_wren, 0);
    check("mrst_done", done, 0);
    check("mrst_req_ack", req_ack, 0);
    step();
    check("mrst_state2", state, IDLE);
    check("mrst_done2", done, 0);
    check("mrst_no_pending", exp_q.size(), 0);
    mem_ui_rdy = 1'b1;

    // Read stalled by the UI in READ_DATA0
    exp_q.push_back(ev(K_ACK, 3'b0, 32'h0));
    mem_ui_rdy = 1'b0;
    issue(1'b0, 32'h5000, 6'd0);
    repeat (3) step();
    check("stall_rd0", state, READ_DATA0);
`ifdef MPMC11_SEQ_WATCHDOG_EN
    exp_q.push_back(ev(K_ERR, 3'b0, 32'h0));
    repeat (14) step();
    check("wd_no_err_early", err, 0);
    step();
    check("wd_err", err, 1);
    check("wd_state_before", state, READ_DATA0);
    req = 1'b0;
    step();
    check("wd_idle", state, IDLE);
    check("wd_err_clr", err, 0);
    check("wd_no_done", done, 0);
    mem_ui_rdy = 1'b1;
    step();
    check("wd_stay_idle", state, IDLE);
`else
    exp_q.push_back(ev(K_CMD, 3'b001, 32'h5000));
    exp_q.push_back(ev(K_DONE, 3'b0, 32'h0));
    repeat (40) step();
    check("stall_hold", state, READ_DATA0);
    check("stall_err", err, 0);
    check("stall_mem_en", mem_en, 1);
    mem_ui_rdy = 1'b1;
    step();
    check("stall_rd1", state, READ_DATA1);
    mem_rd_valid = 1'b1; step(); mem_rd_valid = 1'b0;
    check("stall_wait", state, WAIT_NACK);
    req = 1'b0;
    step();
    check("stall_idle", state, IDLE);
`endif

    step();
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mpmc11_state_seq.md
Name: mpmc11_state_seq

Overview:
- Producer side of the mpmc11 controller state bus. Generates the `mpmc11_state_t` sequence that the previous-state tracker and the output decoders consume.
- Accepts one burst request from the port arbiter and drives the memory UI command and write-data handshakes until all beats are done.
- Returns to IDLE once the requester drops its request.
- Sits between the arbiter and the memory UI (MIG-style app interface).

Parameters:
- AW, 32, address width of req_adr and mem_addr.
- LW, 6, width of the burst length field; a burst is req_len+1 beats.
- STRIDE, 16, byte increment of mem_addr per beat.
- TMO, 1023, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  controller clock
- rstn  in  1  synchronous active-low reset
- req  in  1  burst request from arbiter; level, held until done seen
- req_we  in  1  1 = write burst, 0 = read burst; sampled in IDLE
- req_adr  in  AW  start byte address; sampled in IDLE
- req_len  in  LW  beats minus one; sampled in IDLE
- mem_ui_rdy  in  1  UI accepts command this cycle
- mem_wdf_rdy  in  1  UI accepts write data this cycle
- mem_rd_valid  in  1  one read beat returned this cycle
- state  out  mpmc11_state_t  current controller state
- req_ack  out  1  one-cycle pulse when a request is captured
- mem_en  out  1  command valid
- mem_cmd  out  3  3'b000 write, 3'b001 read
- mem_addr  out  AW  command address
- mem_wdf_wren  out  1  write data valid
- mem_wdf_end  out  1  last word of write data; same cycle as wren
- done  out  1  burst complete; held in WAIT_NACK
- err  out  1  watchdog abort pulse; always 0 when the feature is absent

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE; addr, beat and return counters=0; captured we/len=0.
  - All outputs 0 next cycle. mem_cmd=3'b001 and mem_addr=0 while idle.
  - Reset mid-burst abandons the burst; no done or req_ack pulse is produced.
- State register changes only on clk. Outputs are combinational decodes of the registered state and counters, except req_ack, which is registered.
- IDLE: on req=1, capture we, adr, len; clear counters; req_ack=1 for exactly the next cycle; go to PRESET1.
- PRESET1 -> PRESET2, unconditionally, one cycle each. This gives fixed 2-cycle setup latency from capture to the first UI activity.
- PRESET2: go to WRITE_DATA0 if we=1, else READ_DATA0.
- WRITE_DATA0:
  - Drive mem_wdf_wren=1 and mem_wdf_end=1 (one UI word per beat).
  - Hold until mem_wdf_rdy=1, then go to WRITE_DATA1.
- WRITE_DATA1:
  - Drive mem_en=1, mem_cmd=000, mem_addr=current address.
  - Hold until mem_ui_rdy=1.
  - On accept: address += STRIDE; if beat counter == len, go to WAIT_NACK; else beat counter +1 and go to WRITE_DATA0.
- READ_DATA0:
  - Drive mem_en=1, mem_cmd=001, mem_addr=current address.
  - Each cycle with mem_ui_rdy=1 advances address and beat counter (back-to-back commands allowed).
  - When the command for beat len is accepted, go to READ_DATA1.
- Return counting: mem_rd_valid increments the return counter in any read state, including READ_DATA0. Early returns are never lost.
- READ_DATA1: wait until returns == len+1, counting a return in the current cycle, then go to WAIT_NACK.
- WAIT_NACK: done=1; stay while req=1; go to IDLE when req=0. A new request is not accepted until IDLE is reached.
- Arithmetic:
  - mem_addr wraps modulo 2^AW.
  - Counters are LW+1 bits wide, so len=2^LW-1 is legal.
  - len=0 gives a single beat.
- Simultaneous events: mem_wdf_rdy or mem_ui_rdy arriving in the same cycle that the state is entered counts as acceptance in that cycle.
- mem_rd_valid outside the read states is ignored.

Optional Feature:
- Macro: MPMC11_SEQ_WATCHDOG_EN.
- With the macro defined:
  - A cycle counter clears whenever state changes or state is IDLE/WAIT_NACK, and increments otherwise.
  - When it reaches TMO, the next state is IDLE, err=1 for one cycle, and done is not asserted.
- Without the macro: no counter is built, err is tied to 0, and a stalled UI holds the state indefinitely.

Test Plan:
- Reset held low for 3 cycles mid-write -> state=IDLE, mem_en=0, wren=0, done=0, req_ack=0 on the first post-reset cycle.
- Write, req_len=2, adr=0x1000, rdy signals always 1 -> PRESET1, PRESET2, then 3×(WRITE_DATA0, WRITE_DATA1); mem_addr 0x1000/0x1010/0x1020; done high until req drops.
- Read, req_len=3, ui_rdy toggling 1,0,1,..., rd_valid returns delayed 5 cycles -> exactly 4 commands at +16 steps; READ_DATA1 exits only after the 4th rd_valid.
- Read with a rd_valid arriving in the same cycle as the first command accept -> return counted, burst completes after 4 total returns and no more.
- Address 0xFFFFFFF0, write len=1 -> second command at 0x00000000.
- With MPMC11_SEQ_WATCHDOG_EN, TMO=15, mem_ui_rdy stuck 0 in READ_DATA0 -> after 15 stalled cycles, err pulses once, state=IDLE, done never asserted; without the macro, state stays READ_DATA0.
